// File: rtl/dsp_preadd_mac.sv
// Four-stage signed pre-add / multiply / post-add pipeline (DSP48-style slice).
// Define DSP_PREADD_MAC_SAT_EN to clamp the S4 result and report it on sat.
module dsp_preadd_mac #(
    parameter  int AW = 16,
    parameter  int CW = 16,
    parameter  int GW = 8,
    localparam int PW = AW + CW + 1 + GW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic [1:0]           pre_mode,
    input  logic [1:0]           post_op,
    input  logic                 clr,
    input  logic signed [AW-1:0] a,
    input  logic signed [AW-1:0] b,
    input  logic signed [CW-1:0] c,
    input  logic signed [PW-1:0] d,
    output logic                 out_valid,
    output logic signed [PW-1:0] p_out,
    output logic                 sat
);
    localparam int MW = AW + 1 + CW;
`ifdef DSP_PREADD_MAC_SAT_EN
    localparam int SW = PW + 1;
`else
    localparam int SW = PW;
`endif

    // valid shift register, one bit per stage; [4] is out_valid
    logic [4:1]           r_vld;

    logic signed [AW-1:0] r1_a, r1_b;
    logic signed [CW-1:0] r1_c;
    logic signed [PW-1:0] r1_d;
    logic [1:0]           r1_pre, r1_op;
    logic                 r1_clr;

    logic signed [AW:0]   r2_a;
    logic signed [CW-1:0] r2_c;
    logic signed [PW-1:0] r2_d;
    logic [1:0]           r2_op;
    logic                 r2_clr;

    logic signed [MW-1:0] r3_m;
    logic signed [PW-1:0] r3_d;
    logic [1:0]           r3_op;
    logic                 r3_clr;

    logic signed [PW-1:0] r_p;

    logic signed [AW:0]   w_ax, w_bx, w_pre;
    logic signed [MW-1:0] w_m;
    logic signed [SW-1:0] w_m4, w_d4, w_p4, w_sum;
    logic signed [PW-1:0] w_pnext;

    assign w_ax = {r1_a[AW-1], r1_a};
    assign w_bx = {r1_b[AW-1], r1_b};

    always_comb begin
        w_pre = w_ax + w_bx;
        case (r1_pre)
            2'b00:   w_pre = w_ax + w_bx;
            2'b01:   w_pre = w_ax - w_bx;
            2'b10:   w_pre = w_ax;
            default: w_pre = w_bx - w_ax;
        endcase
    end

    assign w_m  = MW'(r2_a) * MW'(r2_c);

    assign w_m4 = SW'(r3_m);
    assign w_d4 = SW'(r3_d);
    assign w_p4 = SW'(r_p);

    // clr only restarts the sum for the accumulate op
    always_comb begin
        w_sum = w_m4;
        case (r3_op)
            2'b00:   w_sum = w_m4 + w_d4;
            2'b01:   w_sum = r3_clr ? w_m4 : (w_p4 + w_m4);
            2'b10:   w_sum = w_d4 - w_m4;
            default: w_sum = w_m4;
        endcase
    end

`ifdef DSP_PREADD_MAC_SAT_EN
    logic w_ovf;
    logic r_sat;

    // out of PW range when the extra top bit disagrees with the PW sign bit
    assign w_ovf   = w_sum[SW-1] ^ w_sum[SW-2];
    assign w_pnext = !w_ovf      ? w_sum[PW-1:0] :
                     w_sum[SW-1] ? {1'b1, {(PW-1){1'b0}}} :
                                   {1'b0, {(PW-1){1'b1}}};

    always_ff @(posedge clk) begin
        if (rst)
            r_sat <= 1'b0;
        else if (ce && r_vld[3])
            r_sat <= w_ovf;
    end

    assign sat = r_sat;
`else
    assign w_pnext = w_sum;
    assign sat     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= '0;
            r1_a   <= '0;
            r1_b   <= '0;
            r1_c   <= '0;
            r1_d   <= '0;
            r1_pre <= '0;
            r1_op  <= '0;
            r1_clr <= 1'b0;
            r2_a   <= '0;
            r2_c   <= '0;
            r2_d   <= '0;
            r2_op  <= '0;
            r2_clr <= 1'b0;
            r3_m   <= '0;
            r3_d   <= '0;
            r3_op  <= '0;
            r3_clr <= 1'b0;
            r_p    <= '0;
        end else if (ce) begin
            r_vld  <= {r_vld[3:1], in_valid};
            r1_a   <= a;
            r1_b   <= b;
            r1_c   <= c;
            r1_d   <= d;
            r1_pre <= pre_mode;
            r1_op  <= post_op;
            r1_clr <= clr;
            r2_a   <= w_pre;
            r2_c   <= r1_c;
            r2_d   <= r1_d;
            r2_op  <= r1_op;
            r2_clr <= r1_clr;
            r3_m   <= w_m;
            r3_d   <= r2_d;
            r3_op  <= r2_op;
            r3_clr <= r2_clr;
            // bubbles must not disturb the accumulator
            if (r_vld[3])
                r_p <= w_pnext;
        end
    end

    assign out_valid = r_vld[4];
    assign p_out     = r_p;

endmodule

// File: doc/dsp_preadd_mac.md
Name: dsp_preadd_mac

Overview:
- Parametrised 4-stage signed DSP pipeline: pre-adder (runtime mode), multiplier, post-adder with runtime operation select including accumulate.
- Valid-qualified and clock-enabled; control travels with its data.
- Maps onto a single DSP48-class slice for default widths.
- Generic multiply-add engine for filter and MAC datapaths.

Parameters:
- AW, 16, width of pre-adder operands a and b (signed)
- CW, 16, width of multiplier operand c (signed)
- GW, 8, accumulator guard bits
- PW, AW+CW+1+GW, width of d and of the result (derived; do not override)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ce  in  1  clock enable for every register in the block
- in_valid  in  1  input sample valid
- pre_mode  in  2  pre-adder mode: 00 a+b, 01 a-b, 10 a, 11 b-a
- post_op  in  2  post op: 00 M+D, 01 P+M (accumulate), 10 D-M, 11 M
- clr  in  1  accumulator clear, sampled with the sample
- a  in  AW  signed operand
- b  in  AW  signed operand
- c  in  CW  signed multiplier operand
- d  in  PW  signed addend
- out_valid  out  1  result valid
- p_out  out  PW  signed result
- sat  out  1  saturation occurred on this result (optional feature only)

Behaviour:
- All registers update only when ce=1; ce=0 freezes the whole pipeline, including out_valid and p_out.
- Reset:
  - rst=1 (priority over ce) clears all data, control and valid registers to 0.
  - p_out=0, out_valid=0, sat=0.
  - A sample in flight is discarded; no out_valid is produced for it.
- Pipeline with ce held high; latency is exactly 4 cycles from in_valid sampled to out_valid:
  - S1: register a, b, c, d, pre_mode, post_op, clr and in_valid.
  - S2: pre-adder result A (AW+1 bits, sign-extended, exact).
  - S3: M = A*c (AW+1+CW bits, exact); d, post_op, clr and valid delayed to align.
  - S4: P register, result width PW, operands sign-extended to PW.
- One result is issued per valid input; throughput is 1 sample per enabled cycle.
- P updates only when S3 valid=1. Bubbles (valid=0) leave P unchanged and drive out_valid=0.
- Post ops at S4:
  - 00: P = M + D
  - 01: P = P + M when clr=0; P = M when clr=1 (clr starts a new sum)
  - 10: P = D - M
  - 11: P = M
- clr is ignored for post ops other than 01.
- Back-to-back accumulate samples each see the P of the immediately preceding valid sample. No hazard exists because P is a single feedback register.
- Changing post_op between samples takes effect per sample with no flush.
- Overflow, default build: two's-complement wrap modulo 2^PW. sat is tied to 0.
- out_valid is a registered copy of the S4 valid bit. p_out always equals P.

Optional Feature:
- Macro: DSP_PREADD_MAC_SAT_EN.
- Defined:
  - The S4 sum is computed in PW+1 bits.
  - If the result exceeds the signed PW range, P clamps to +2^(PW-1)-1 or -2^(PW-1).
  - sat=1 for that result; sat is registered alongside out_valid.
  - Accumulation continues from the clamped value.
- Undefined: wrap behaviour as above; sat constant 0; no extra logic is generated.

Test Plan:
- Pre-adder modes, post_op=11, a=100, b=30, c=2, in_valid for one cycle -> out_valid exactly 4 cycles later:
  - pre_mode 00 -> p_out=260
  - pre_mode 01 -> p_out=140
  - pre_mode 10 -> p_out=200
  - pre_mode 11 -> p_out=-140
- Post ops 00/10, a=-5, b=0, c=7, d=1000: pre_mode 10, post_op 00 -> 965; post_op 10 -> 1035.
- Accumulate run: 4 back-to-back samples a=1, b=2, c=3, pre_mode 00, post_op 01, clr=1 on the first only -> p_out 9, 18, 27, 36.
  - A fifth sample with clr=1 and c=1 -> p_out=3.
- Stall and bubble:
  - Same run with ce deasserted 3 cycles mid-run -> outputs frozen during the stall, values unchanged, total latency +3.
  - in_valid gaps -> P held, out_valid=0 in gap cycles.
- Reset mid-operation: rst asserted 1 cycle while 2 samples are in flight -> out_valid never asserts for them; p_out=0; the next accumulate sample with clr=0 sums from 0.
- Overflow, accumulate with a=b=32767, c=32767, pre_mode 00, post_op 01 repeated until the sum passes 2^40-1:
  - Default build -> p_out wraps negative, sat=0.
  - DSP_PREADD_MAC_SAT_EN -> p_out=2^40-1, sat=1, and p_out holds at the clamp on further samples.
